// File: rtl/mips_mem_pkg.sv
// Shared memory-stage types: store-kind encoding, buffered store entry and byte-mask helper.
package mips_mem_pkg;

  typedef enum logic [2:0] {
    ST_NONE = 3'd0,
    ST_SB   = 3'd1,
    ST_SH   = 3'd2,
    ST_SW   = 3'd3,
    ST_SWL  = 3'd4,
    ST_SWR  = 3'd5
  } stMode_e;

  typedef struct packed {
    logic [29:0] wordAddr;
    logic [31:0] data;
    logic [3:0]  be;
  } stEntry_t;

  function automatic logic [31:0] beToMask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Store lane alignment: mode/byte offset/rt -> byte enables, lane-aligned data, misalignment flag.
module store_lane_align
  import mips_mem_pkg::*;
(
  input  logic [2:0]  mode,
  input  logic [1:0]  byteOff,
  input  logic [31:0] rtData,
  output logic [3:0]  be,
  output logic [31:0] data,
  output logic        err,
  output logic        legal
);

  logic [4:0] shiftAmt;
  assign shiftAmt = {byteOff, 3'b000};

  always_comb begin
    be    = '0;
    data  = '0;
    err   = 1'b0;
    legal = 1'b0;
    case (mode)
      ST_SB: begin
        be    = 4'b0001 << byteOff;
        data  = {24'b0, rtData[7:0]} << shiftAmt;
        legal = 1'b1;
      end
      ST_SH: begin
        if (byteOff[0]) begin
          err = 1'b1;
        end else begin
          be    = 4'b0011 << byteOff;
          data  = {16'b0, rtData[15:0]} << shiftAmt;
          legal = 1'b1;
        end
      end
      ST_SW: begin
        if (byteOff != 2'd0) begin
          err = 1'b1;
        end else begin
          be    = 4'b1111;
          data  = rtData;
          legal = 1'b1;
        end
      end
      // SWL keeps the top k+1 bytes of rt; ~k equals 3-k for a 2-bit offset
      ST_SWL: begin
        be    = 4'b1111 >> (~byteOff);
        data  = rtData >> {~byteOff, 3'b000};
        legal = 1'b1;
      end
      ST_SWR: begin
        be    = 4'b1111 << byteOff;
        data  = rtData << shiftAmt;
        legal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_buffer_m.sv
// M-stage store buffer: aligns stores, queues them in a FIFO and drains over req/ack.
// Optional macro STBUF_COALESCE_EN merges a store into the tail entry when it targets the same word.
module store_buffer_m
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [2:0]       st_mode,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  output logic             st_ready,
  output logic             st_err,
  output logic             mem_req,
  output logic [29:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ack,
  input  logic [31:0]      ld_addr,
  output logic             ld_hit,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  stEntry_t         entries [DEPTH];
  logic [DEPTH-1:0] validVec;
  logic [PTR_W-1:0] headPtr, tailPtr;
  logic [CNT_W-1:0] cnt;
  logic             errQ;

  logic [3:0]  newBe;
  logic [31:0] newData;
  logic        alignErr, alignLegal;
  logic        notFull, mergeOk, accept, doPush, pop;
  logic        unusedLdBits;

  store_lane_align uAlign (
    .mode    (st_mode),
    .byteOff (st_addr[1:0]),
    .rtData  (st_data),
    .be      (newBe),
    .data    (newData),
    .err     (alignErr),
    .legal   (alignLegal)
  );

  assign notFull = (cnt < CNT_W'(DEPTH));
  assign mem_req = (cnt != '0);
  assign pop     = mem_req & mem_ack;

`ifdef STBUF_COALESCE_EN
  logic [PTR_W-1:0] tailLast;
  stEntry_t         mergedEntry;

  assign tailLast = tailPtr - PTR_W'(1);
  // The head on the bus must stay stable, so it is never a merge target
  assign mergeOk  = validVec[tailLast]
                    && (entries[tailLast].wordAddr == st_addr[31:2])
                    && !(mem_req && (tailLast == headPtr));

  always_comb begin
    mergedEntry          = entries[tailLast];
    mergedEntry.be       = entries[tailLast].be | newBe;
    mergedEntry.data     = (entries[tailLast].data & ~beToMask(newBe)) | (newData & beToMask(newBe));
  end
`else
  assign mergeOk = 1'b0;
`endif

  assign st_ready = notFull | mergeOk;
  assign accept   = st_valid & alignLegal & st_ready;
  assign doPush   = accept & !mergeOk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      cnt      <= '0;
      validVec <= '0;
      errQ     <= 1'b0;
    end else begin
      errQ <= st_valid & alignErr;
      if (pop) begin
        validVec[headPtr] <= 1'b0;
        headPtr           <= headPtr + PTR_W'(1);
      end
      if (doPush) begin
        validVec[tailPtr] <= 1'b1;
        tailPtr           <= tailPtr + PTR_W'(1);
      end
      cnt <= cnt + CNT_W'(doPush) - CNT_W'(pop);
    end
  end

  // Entry storage needs no reset: validVec and cnt gate every use of it
  always_ff @(posedge clk) begin
    if (doPush) begin
      entries[tailPtr] <= '{wordAddr: st_addr[31:2], data: newData, be: newBe};
    end
`ifdef STBUF_COALESCE_EN
    else if (accept && mergeOk) begin
      entries[tailLast] <= mergedEntry;
    end
`endif
  end

  assign mem_addr  = mem_req ? entries[headPtr].wordAddr : '0;
  assign mem_wdata = mem_req ? entries[headPtr].data     : '0;
  assign mem_be    = mem_req ? entries[headPtr].be       : '0;
  assign count     = cnt;
  assign empty     = (cnt == '0);
  assign st_err    = errQ;

  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (validVec[i] && (entries[i].wordAddr == ld_addr[31:2])) ld_hit = 1'b1;
    end
  end

  assign unusedLdBits = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_buffer_m.sv
// Self-checking bench for store_buffer_m: alignment vector table, scoreboard monitor, corner-case sequences.
module tb_store_buffer_m;
  import mips_mem_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             st_valid;
  logic [2:0]       st_mode;
  logic [31:0]      st_addr, st_data;
  logic             st_ready, st_err;
  logic             mem_req, mem_ack;
  logic [29:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;
  logic [31:0]      ld_addr;
  logic             ld_hit;
  logic [CNT_W-1:0] count;
  logic             empty;

  store_buffer_m #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_mode(st_mode),
    .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready), .st_err(st_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .ld_addr(ld_addr), .ld_hit(ld_hit), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Byte-by-byte reference for the store lane mapping
  function automatic void modelAlign(input logic [2:0] mode, input logic [31:0] addr,
                                     input logic [31:0] rt, output logic [3:0] be,
                                     output logic [31:0] wd, output logic err, output logic ok);
    int k;
    k  = int'(addr[1:0]);
    be = '0;
    wd = '0;
    for (int j = 0; j < 4; j++) begin
      int src;
      src = -1;
      case (mode)
        3'd1: if (j == k) src = 0;
        3'd2: if ((k % 2 == 0) && (j == k || j == k + 1)) src = j - k;
        3'd3: if (k == 0) src = j;
        3'd4: if (j <= k) src = 3 - k + j;
        3'd5: if (j >= k) src = j - k;
        default: ;
      endcase
      if (src >= 0) begin
        be[j]        = 1'b1;
        wd[8*j +: 8] = rt[8*src +: 8];
      end
    end
    err = (mode == 3'd2 && (k % 2) == 1) || (mode == 3'd3 && k != 0);
    ok  = (mode >= 3'd1 && mode <= 3'd5) && !err;
  endfunction

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } ent_t;

  ent_t sbq[$];
  bit   sbOn    = 1'b0;
  logic errPend = 1'b0;

  always @(negedge clk) begin
    logic [3:0]  mBe;
    logic [31:0] mWd;
    logic        mErr, mOk;
    bit          hit;
    int          sz;
    ent_t        e;
    if (sbOn) begin
      sz = sbq.size();
      chk("sb_count",    32'(count),    32'(sz));
      chk("sb_st_ready", 32'(st_ready), 32'(sz < DEPTH));
      chk("sb_mem_req",  32'(mem_req),  32'(sz != 0));
      chk("sb_st_err",   32'(st_err),   32'(errPend));
      hit = 1'b0;
      foreach (sbq[i]) if (sbq[i].a == ld_addr[31:2]) hit = 1'b1;
      chk("sb_ld_hit", 32'(ld_hit), 32'(hit));
      if (sz != 0) begin
        chk("sb_head_addr", 32'(mem_addr), 32'(sbq[0].a));
        chk("sb_head_be",   32'(mem_be),   32'(sbq[0].b));
        chk("sb_head_data", mem_wdata,     sbq[0].d);
      end
      modelAlign(st_mode, st_addr, st_data, mBe, mWd, mErr, mOk);
      errPend = st_valid && mErr;
      if (mem_req && mem_ack && sz != 0) void'(sbq.pop_front());
      if (st_valid && mOk && sz < DEPTH) begin
        e.a = st_addr[31:2];
        e.d = mWd;
        e.b = mBe;
        sbq.push_back(e);
      end
    end
  end

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        err;
    logic        enq;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{ST_SB,   32'h1003, 32'h000000AB, 4'b1000, 32'hAB000000, 1'b0, 1'b1};
    vecs[1]  = '{ST_SWL,  32'h0011, 32'h11223344, 4'b0011, 32'h00001122, 1'b0, 1'b1};
    vecs[2]  = '{ST_SWR,  32'h0012, 32'h11223344, 4'b1100, 32'h33440000, 1'b0, 1'b1};
    vecs[3]  = '{ST_SH,   32'h0022, 32'h1234ABCD, 4'b1100, 32'hABCD0000, 1'b0, 1'b1};
    vecs[4]  = '{ST_SW,   32'h0100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b1};
    vecs[5]  = '{ST_SB,   32'h0005, 32'h12345677, 4'b0010, 32'h00007700, 1'b0, 1'b1};
    vecs[6]  = '{ST_SWL,  32'h0013, 32'h11223344, 4'b1111, 32'h11223344, 1'b0, 1'b1};
    vecs[7]  = '{ST_SWR,  32'h0010, 32'h11223344, 4'b1111, 32'h11223344, 1'b0, 1'b1};
    vecs[8]  = '{ST_SWL,  32'h0010, 32'h11223344, 4'b0001, 32'h00000011, 1'b0, 1'b1};
    vecs[9]  = '{ST_SWR,  32'h0013, 32'h11223344, 4'b1000, 32'h44000000, 1'b0, 1'b1};
    vecs[10] = '{ST_SW,   32'h0022, 32'h11223344, 4'b0000, 32'h00000000, 1'b1, 1'b0};
    vecs[11] = '{ST_SH,   32'h0021, 32'h11223344, 4'b0000, 32'h00000000, 1'b1, 1'b0};
    vecs[12] = '{ST_NONE, 32'h0040, 32'h11223344, 4'b0000, 32'h00000000, 1'b0, 1'b0};

    reset = 1'b0; st_valid = 1'b0; st_mode = '0; st_addr = '0; st_data = '0;
    mem_ack = 1'b0; ld_addr = '0;
    repeat (2) step();
    chk("rst_count",  32'(count),    32'd0);
    chk("rst_empty",  32'(empty),    32'd1);
    chk("rst_memreq", 32'(mem_req),  32'd0);
    chk("rst_sterr",  32'(st_err),   32'd0);
    chk("rst_ldhit",  32'(ld_hit),   32'd0);
    chk("rst_addr",   32'(mem_addr), 32'd0);
    chk("rst_wdata",  mem_wdata,     32'd0);
    chk("rst_be",     32'(mem_be),   32'd0);
    reset = 1'b1;
    step();
    sbOn = 1'b1;

    // Alignment table: one store, check the head next cycle, then pop it
    foreach (vecs[i]) begin
      st_valid = 1'b1; st_mode = vecs[i].mode; st_addr = vecs[i].addr; st_data = vecs[i].data;
      step();
      st_valid = 1'b0; st_mode = '0;
      chk($sformatf("vec%0d_err", i), 32'(st_err), 32'(vecs[i].err));
      chk($sformatf("vec%0d_req", i), 32'(mem_req), 32'(vecs[i].enq));
      if (vecs[i].enq) begin
        chk($sformatf("vec%0d_addr", i),  32'(mem_addr), 32'(vecs[i].addr[31:2]));
        chk($sformatf("vec%0d_be", i),    32'(mem_be),   32'(vecs[i].be));
        chk($sformatf("vec%0d_wdata", i), mem_wdata,     vecs[i].wdata);
        mem_ack = 1'b1;
      end
      step();
      mem_ack = 1'b0;
      chk($sformatf("vec%0d_cnt", i), 32'(count), 32'd0);
    end

    // Fill, attempt an extra push while full, hold, then pop once with a push pending
    for (int i = 0; i < DEPTH; i++) begin
      st_valid = 1'b1; st_mode = ST_SW; st_addr = 32'h1000 + 32'(4 * i); st_data = 32'hC0DE0000 + 32'(i);
      step();
    end
    st_addr = 32'h2000;
    chk("full_ready", 32'(st_ready), 32'd0);
    chk("full_count", 32'(count),    32'd4);
    chk("full_addr",  32'(mem_addr), 32'h400);
    repeat (2) step();
    chk("hold_addr",  32'(mem_addr), 32'h400);
    chk("hold_data",  mem_wdata,     32'hC0DE0000);
    chk("hold_count", 32'(count),    32'd4);
    mem_ack = 1'b1;
    step();
    st_valid = 1'b0;
    mem_ack  = 1'b0;
    chk("pulse_count", 32'(count),    32'd3);
    chk("pulse_ready", 32'(st_ready), 32'd1);
    chk("pulse_addr",  32'(mem_addr), 32'h401);
    mem_ack = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      step();
      chk($sformatf("drain_cnt%0d", i), 32'(count), 32'(i));
    end
    mem_ack = 1'b0;

    // Load hazard detection, including the entry popped this cycle
    st_valid = 1'b1; st_mode = ST_SW; st_addr = 32'h100; st_data = 32'h55;
    step();
    st_valid = 1'b0;
    ld_addr = 32'h102; #1;
    chk("ld_same_word", 32'(ld_hit), 32'd1);
    ld_addr = 32'h104; #1;
    chk("ld_next_word", 32'(ld_hit), 32'd0);
    ld_addr = 32'h100; mem_ack = 1'b1; #1;
    chk("ld_popping", 32'(ld_hit), 32'd1);
    step();
    mem_ack = 1'b0; #1;
    chk("ld_after_pop", 32'(ld_hit), 32'd0);

    // Reset in the middle of a drain
    st_valid = 1'b1; st_mode = ST_SW; st_addr = 32'h500;
    step();
    st_addr = 32'h504;
    step();
    st_valid = 1'b0;
    sbOn = 1'b0;
    sbq.delete();
    ld_addr = 32'h500;
    mem_ack = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count),    32'd0);
    chk("mid_rst_req",   32'(mem_req),  32'd0);
    chk("mid_rst_empty", 32'(empty),    32'd1);
    chk("mid_rst_addr",  32'(mem_addr), 32'd0);
    chk("mid_rst_ldhit", 32'(ld_hit),   32'd0);
    step();
    reset = 1'b1; mem_ack = 1'b0;
    step();
    chk("post_rst_count", 32'(count), 32'd0);

    // Same-word stores behind a different head word
    st_valid = 1'b1; st_mode = ST_SW; st_addr = 32'h300; st_data = 32'hAAAAAAAA;
    step();
    st_addr = 32'h200; st_data = 32'h11223344;
    step();
    st_mode = ST_SB; st_addr = 32'h201; st_data = 32'h000000EE;
    step();
    st_valid = 1'b0;
`ifdef STBUF_COALESCE_EN
    chk("coal_count", 32'(count), 32'd2);
`else
    chk("coal_count", 32'(count), 32'd3);
`endif
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("coal_addr", 32'(mem_addr), 32'h80);
    chk("coal_be",   32'(mem_be),   32'hF);
`ifdef STBUF_COALESCE_EN
    chk("coal_data", mem_wdata, 32'h1122EE44);
`else
    chk("coal_data", mem_wdata, 32'h11223344);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("sep_addr", 32'(mem_addr), 32'h80);
    chk("sep_be",   32'(mem_be),   32'b0010);
    chk("sep_data", mem_wdata,     32'h0000EE00);
`endif
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("final_empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
